// File: rtl/exec_stage_pkg.sv
// Shared definitions for the execute stage: ALU op codes, muldiv FSM states and step count.
package exec_stage_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_NOR   = 5'd6;
  localparam logic [4:0] OP_SLT   = 5'd7;
  localparam logic [4:0] OP_SLTU  = 5'd8;
  localparam logic [4:0] OP_SLL   = 5'd9;
  localparam logic [4:0] OP_SRL   = 5'd10;
  localparam logic [4:0] OP_SRA   = 5'd11;
  localparam logic [4:0] OP_LUI   = 5'd12;
  localparam logic [4:0] OP_MULT  = 5'd13;
  localparam logic [4:0] OP_MULTU = 5'd14;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_MFHI  = 5'd17;
  localparam logic [4:0] OP_MFLO  = 5'd18;
  localparam logic [4:0] OP_MTHI  = 5'd19;
  localparam logic [4:0] OP_MTLO  = 5'd20;
  localparam logic [4:0] OP_SEQ   = 5'd21;
  localparam logic [4:0] OP_LINK  = 5'd22;

  localparam int MULDIV_STEPS = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/exec_stage_muldiv_iter.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// FAST_MUL_EN: multiplies complete in a single step; divides stay iterative.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             stall_in,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  import exec_stage_pkg::*;

  localparam int CW = $clog2(MULDIV_STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(MULDIV_STEPS - 1);

  md_state_t          state_reg;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   op_reg;
  logic [WIDTH-1:0]   rs_raw_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               is_div_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               div_zero_reg;

  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  assign rs_neg = is_signed & rs[WIDTH-1];
  assign rt_neg = is_signed & rt[WIDTH-1];
  assign rs_mag = rs_neg ? -rs : rs;
  assign rt_mag = rt_neg ? -rt : rt;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, op_reg} : '0);
  assign rem_sh   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, op_reg};
  // rem_sh < 2*divisor, so a borrow into the top bit means rem_sh < divisor.
  assign rem_ge   = ~rem_diff[WIDTH];
  assign acc_step = is_div_reg
                  ? {(rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_reg[WIDTH-2:0], rem_ge}
                  : {mul_sum, acc_reg[WIDTH-1:1]};
  assign prod_fix = neg_q_reg ? -acc_step : acc_step;

  always_comb begin
    fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    fin_lo = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      if (div_zero_reg) begin
        fin_hi = rs_raw_reg;
        fin_lo = '1;
      end else begin
        fin_hi = neg_r_reg ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        fin_lo = neg_q_reg ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
      end
    end
  end

`ifdef FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  // Extend to double width so one truncated product serves signed and unsigned.
  assign fast_prod = {{WIDTH{rs_neg}}, rs} * {{WIDTH{rt_neg}}, rt};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= MD_IDLE;
      count_reg    <= '0;
      acc_reg      <= '0;
      op_reg       <= '0;
      rs_raw_reg   <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        MD_IDLE: begin
          if (start) begin
            is_div_reg   <= is_div;
            op_reg       <= is_div ? rt_mag : rs_mag;
            acc_reg      <= {{WIDTH{1'b0}}, (is_div ? rs_mag : rt_mag)};
            neg_q_reg    <= rs_neg ^ rt_neg;
            neg_r_reg    <= rs_neg;
            div_zero_reg <= (rt == '0);
            rs_raw_reg   <= rs;
            count_reg    <= '0;
            state_reg    <= MD_BUSY;
`ifdef FAST_MUL_EN
            if (!is_div) begin
              hi_reg    <= fast_prod[2*WIDTH-1:WIDTH];
              lo_reg    <= fast_prod[WIDTH-1:0];
              state_reg <= MD_DONE;
            end
`endif
          end else begin
            if (hi_we) hi_reg <= wdata;
            if (lo_we) lo_reg <= wdata;
          end
        end
        MD_BUSY: begin
          acc_reg   <= acc_step;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST_STEP) begin
            hi_reg    <= fin_hi;
            lo_reg    <= fin_lo;
            state_reg <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (!stall_in) state_reg <= MD_IDLE;
        end
        default: state_reg <= MD_IDLE;
      endcase
    end
  end

  assign hi   = hi_reg;
  assign lo   = lo_reg;
  assign busy = (state_reg != MD_IDLE);
  assign done = (state_reg == MD_DONE);

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU, branch resolution and the HI/LO muldiv unit.
// FAST_MUL_EN selects a single-step multiplier inside muldiv_iter.
module exec_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall_in,
  input  logic [ADDR_WIDTH-1:0]   pc_in,
  input  logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]   alu_rs,
  input  logic [DATA_WIDTH-1:0]   alu_rt,
  input  logic                    branch_in,
  input  logic [ADDR_WIDTH-1:0]   branch_target_in,
  output logic [DATA_WIDTH-1:0]   alu_result,
  output logic                    branch_taken,
  output logic [ADDR_WIDTH-1:0]   branch_target_out,
  output logic                    flush_req,
  output logic                    stall_req,
  output logic                    busy
);
  import exec_stage_pkg::*;

  logic                  is_md, is_div, is_signed;
  logic                  hi_we, lo_we;
  logic                  md_busy, md_done;
  logic [DATA_WIDTH-1:0] hi, lo;
  logic [DATA_WIDTH-1:0] result;
  logic [4:0]            shamt;

  assign shamt     = alu_rs[4:0];
  assign is_div    = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
  assign is_md     = (alu_op == OP_MULT) || (alu_op == OP_MULTU) || is_div;
  assign is_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign hi_we     = (alu_op == OP_MTHI) && !stall_in;
  assign lo_we     = (alu_op == OP_MTLO) && !stall_in;

  always_comb begin
    result = '0;
    case (alu_op)
      OP_ADD:  result = alu_rs + alu_rt;
      OP_SUB:  result = alu_rs - alu_rt;
      OP_AND:  result = alu_rs & alu_rt;
      OP_OR:   result = alu_rs | alu_rt;
      OP_XOR:  result = alu_rs ^ alu_rt;
      OP_NOR:  result = ~(alu_rs | alu_rt);
      OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(alu_rs) < $signed(alu_rt))};
      OP_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (alu_rs < alu_rt)};
      OP_SLL:  result = alu_rt << shamt;
      OP_SRL:  result = alu_rt >> shamt;
      OP_SRA:  result = $signed(alu_rt) >>> shamt;
      OP_LUI:  result = DATA_WIDTH'(alu_rt[15:0]) << 16;
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      OP_SEQ:  result = {{(DATA_WIDTH-1){1'b0}}, (alu_rs == alu_rt)};
      OP_LINK: result = DATA_WIDTH'(pc_in + ADDR_WIDTH'(8));
      default: result = '0;
    endcase
  end

  muldiv_iter #(
    .WIDTH(DATA_WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (is_md),
    .is_div   (is_div),
    .is_signed(is_signed),
    .rs       (alu_rs),
    .rt       (alu_rt),
    .stall_in (stall_in),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (alu_rs),
    .hi       (hi),
    .lo       (lo),
    .busy     (md_busy),
    .done     (md_done)
  );

  assign alu_result        = result;
  assign branch_taken      = branch_in & (result != '0);
  assign branch_target_out = branch_target_in;
  assign flush_req         = branch_taken;
  // The IDLE cycle that launches a muldiv stalls too; DONE lets it advance.
  assign stall_req         = rst_n & (md_busy ? !md_done : is_md);
  assign busy              = md_busy;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed ALU table, random ALU/muldiv against a model.
module tb_exec_stage;
  import exec_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic [31:0] pc_in;
  logic [4:0]  alu_op;
  logic [31:0] alu_rs;
  logic [31:0] alu_rt;
  logic        branch_in;
  logic [31:0] branch_target_in;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic [31:0] branch_target_out;
  logic        flush_req;
  logic        stall_req;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

`ifdef FAST_MUL_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = 33;
`endif
  localparam int DIV_STALL = 33;

  exec_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_in         (stall_in),
    .pc_in            (pc_in),
    .alu_op           (alu_op),
    .alu_rs           (alu_rs),
    .alu_rt           (alu_rt),
    .branch_in        (branch_in),
    .branch_target_in (branch_target_in),
    .alu_result       (alu_result),
    .branch_taken     (branch_taken),
    .branch_target_out(branch_target_out),
    .flush_req        (flush_req),
    .stall_req        (stall_req),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pc;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] res;
    logic        taken;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU from arithmetic definitions of each operation.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] rs,
                                         input logic [31:0] rt, input logic [31:0] pc);
    longint a, b, d, q;
    longint unsigned ua, ub, p2;
    int sh;
    a  = longint'($signed(rs));
    b  = longint'($signed(rt));
    ua = longint'(rs);
    ub = longint'(rt);
    sh = int'(rs[4:0]);
    p2 = 64'd1 << sh;
    d  = longint'(p2);
    case (op)
      OP_ADD:  return 32'(ua + ub);
      OP_SUB:  return 32'(ua - ub);
      OP_AND:  return rs & rt;
      OP_OR:   return rs | rt;
      OP_XOR:  return rs ^ rt;
      OP_NOR:  return ~(rs | rt);
      OP_SLT:  return (a < b) ? 32'd1 : 32'd0;
      OP_SLTU: return (ua < ub) ? 32'd1 : 32'd0;
      OP_SLL:  return 32'(ub * p2);
      OP_SRL:  return 32'(ub / p2);
      OP_SRA: begin
        q = b / d;
        if (b < 0 && (b % d) != 0) q = q - 1;
        return 32'(q);
      end
      OP_LUI:  return 32'(longint'(rt[15:0]) * 65536);
      OP_MFHI: return model_hi;
      OP_MFLO: return model_lo;
      OP_SEQ:  return (rs == rt) ? 32'd1 : 32'd0;
      OP_LINK: return pc + 32'd8;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_md(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output logic [31:0] eh, output logic [31:0] el);
    longint a, b, p, q, r;
    longint unsigned up;
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    eh = '0;
    el = '0;
    case (op)
      OP_MULT: begin
        p = a * b;
        eh = p[63:32];
        el = p[31:0];
      end
      OP_MULTU: begin
        up = longint'(rs) * longint'(rt);
        eh = up[63:32];
        el = up[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (rt == 32'd0) begin
          el = 32'hFFFFFFFF;
          eh = rs;
        end else if (op == OP_DIV) begin
          q = a / b;
          r = a % b;
          el = q[31:0];
          eh = r[31:0];
        end else begin
          el = rs / rt;
          eh = rs % rt;
        end
      end
      default: ;
    endcase
  endtask

  task automatic do_muldiv(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt);
    logic [31:0] eh, el;
    int cnt, exp_cnt;
    model_md(op, rs, rt, eh, el);
    exp_cnt = (op == OP_MULT || op == OP_MULTU) ? MUL_STALL : DIV_STALL;
    alu_op = op; alu_rs = rs; alu_rt = rt; branch_in = 1'b0;
    #1;
    check("md_result_zero", alu_result, 32'd0);
    cnt = 0;
    while (stall_req === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
      if (cnt == 1) check("md_busy_after_start", busy, 1'b1);
    end
    check("md_stall_cycles", cnt, exp_cnt);
    tick();
    alu_op = OP_MFLO;
    #1;
    check("md_lo", alu_result, el);
    alu_op = OP_MFHI;
    #1;
    check("md_hi", alu_result, eh);
    check("md_idle_after", busy, 1'b0);
    model_hi = eh;
    model_lo = el;
    $display("muldiv op=%0d rs=%h rt=%h stall=%0d hi=%h lo=%h", op, rs, rt, cnt, eh, el);
  endtask

  initial begin
    logic [4:0]  pool[18];
    logic [4:0]  md_ops[4];
    logic [31:0] exp_res, eh, el, wv;
    logic [4:0]  op;
    int win_lo, win_hi, done_c;

    vecs[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h0,    1'b0, 32'h0,   32'h80000000, 1'b0};
    vecs[1]  = '{OP_SRA,  32'h00000004, 32'hF0000000, 32'h0,    1'b0, 32'h0,   32'hFF000000, 1'b0};
    vecs[2]  = '{OP_LUI,  32'h00000000, 32'h00001234, 32'h0,    1'b0, 32'h0,   32'h12340000, 1'b0};
    vecs[3]  = '{OP_SEQ,  32'h00000005, 32'h00000005, 32'h0,    1'b1, 32'h100, 32'h00000001, 1'b1};
    vecs[4]  = '{OP_SEQ,  32'h00000005, 32'h00000006, 32'h0,    1'b1, 32'h100, 32'h00000000, 1'b0};
    vecs[5]  = '{OP_SUB,  32'h00000000, 32'h00000001, 32'h0,    1'b0, 32'h0,   32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h0,    1'b1, 32'h200, 32'h00000001, 1'b1};
    vecs[7]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h0,    1'b1, 32'h200, 32'h00000000, 1'b0};
    vecs[8]  = '{OP_SLL,  32'h0000001F, 32'h00000003, 32'h0,    1'b0, 32'h0,   32'h80000000, 1'b0};
    vecs[9]  = '{OP_SRL,  32'h00000008, 32'hF0000000, 32'h0,    1'b0, 32'h0,   32'h00F00000, 1'b0};
    vecs[10] = '{OP_NOR,  32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0,    1'b0, 32'h0,   32'h00000000, 1'b0};
    vecs[11] = '{OP_LINK, 32'h0,        32'h0,        32'h1000, 1'b0, 32'h0,   32'h00001008, 1'b0};
    vecs[12] = '{OP_XOR,  32'h00000005, 32'h00000005, 32'h0,    1'b1, 32'h300, 32'h00000000, 1'b0};
    vecs[13] = '{5'd31,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,    1'b1, 32'h400, 32'h00000000, 1'b0};

    pool = '{OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
             OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MFHI, OP_MFLO, OP_SEQ, OP_LINK, 5'd27};
    md_ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};

    // Reset state, with a muldiv op already presented.
    rst_n = 1'b0; stall_in = 1'b0; pc_in = '0; alu_op = OP_MULT;
    alu_rs = 32'd3; alu_rt = 32'd4; branch_in = 1'b0; branch_target_in = '0;
    #2;
    check("reset_stall_req", stall_req, 1'b0);
    check("reset_busy", busy, 1'b0);
    alu_op = OP_MFHI;
    #1;
    check("reset_hi", alu_result, 32'd0);
    alu_op = OP_MFLO;
    #1;
    check("reset_lo", alu_result, 32'd0);
    #8;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      alu_op = vecs[i].op; alu_rs = vecs[i].rs; alu_rt = vecs[i].rt; pc_in = vecs[i].pc;
      branch_in = vecs[i].br; branch_target_in = vecs[i].tgt;
      #1;
      check("vec_result", alu_result, vecs[i].res);
      check("vec_taken", branch_taken, vecs[i].taken);
      check("vec_flush", flush_req, vecs[i].taken);
      check("vec_target", branch_target_out, vecs[i].tgt);
      $display("vector %0d op=%0d rs=%h rt=%h result=%h taken=%0d", i, vecs[i].op,
               vecs[i].rs, vecs[i].rt, alu_result, branch_taken);
      tick();
    end

    do_muldiv(OP_MULT,  32'hFFFFFFFD, 32'd7);
    do_muldiv(OP_DIV,   32'hFFFFFFF9, 32'd2);
    do_muldiv(OP_DIVU,  32'd9,        32'd0);
    do_muldiv(OP_DIV,   32'h80000000, 32'hFFFFFFFF);

    for (int i = 0; i < 40; i++) begin
      op = pool[$urandom_range(0, 17)];
      alu_op = op; alu_rs = $urandom; alu_rt = $urandom; pc_in = $urandom;
      if ($urandom_range(0, 3) == 0) alu_rt = alu_rs;
      branch_in = 1'($urandom_range(0, 1)); branch_target_in = $urandom;
      exp_res = ref_alu(op, alu_rs, alu_rt, pc_in);
      #1;
      check("rand_result", alu_result, exp_res);
      check("rand_taken", branch_taken, branch_in && (exp_res != 0));
      $display("random alu op=%0d rs=%h rt=%h result=%h", op, alu_rs, alu_rt, alu_result);
      tick();
    end

    // Downstream stall held across completion: DONE must hold without restarting.
    branch_in = 1'b0;
    done_c = MUL_STALL;
    win_lo = (done_c > 3) ? done_c - 3 : 0;
    win_hi = done_c + 7;
    alu_op = OP_MULTU; alu_rs = 32'hFFFFFFFF; alu_rt = 32'hFFFFFFFF;
    for (int c = 0; c <= win_hi + 1; c++) begin
      stall_in = (c >= win_lo && c <= win_hi);
      #1;
      check("hold_stall_req", stall_req, c < done_c);
      check("hold_busy", busy, c != 0);
      tick();
    end
    stall_in = 1'b0;
    alu_op = OP_MFLO;
    #1;
    check("hold_lo", alu_result, 32'h00000001);
    alu_op = OP_MFHI;
    #1;
    check("hold_hi", alu_result, 32'hFFFFFFFE);
    check("hold_idle", busy, 1'b0);
    model_hi = 32'hFFFFFFFE; model_lo = 32'h1;
    $display("muldiv held-done multu hi=%h lo=%h", model_hi, model_lo);
    tick();

    for (int i = 0; i < 10; i++) begin
      op = md_ops[$urandom_range(0, 3)];
      wv = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) wv = wv & 32'h0000000F;
      do_muldiv(op, $urandom, wv);
      tick();
    end

    for (int i = 0; i < 4; i++) begin
      wv = $urandom;
      alu_op = (i % 2 == 0) ? OP_MTHI : OP_MTLO; alu_rs = wv;
      if (i % 2 == 0) model_hi = wv; else model_lo = wv;
      tick();
      alu_op = (i % 2 == 0) ? OP_MFHI : OP_MFLO;
      #1;
      check("mt_readback", alu_result, wv);
      $display("move-to op=%0d value=%h", (i % 2 == 0) ? OP_MTHI : OP_MTLO, wv);
      tick();
    end

    // MTHI under downstream stall must not write.
    stall_in = 1'b1; alu_op = OP_MTHI; alu_rs = ~model_hi;
    tick();
    stall_in = 1'b0; alu_op = OP_MFHI;
    #1;
    check("mthi_stalled", alu_result, model_hi);
    tick();

    // Reset in the middle of a divide.
    model_md(OP_DIV, 32'h12345678, 32'h9, eh, el);
    alu_op = OP_DIV; alu_rs = 32'h12345678; alu_rt = 32'h9;
    for (int c = 0; c < 10; c++) tick();
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midreset_stall_req", stall_req, 1'b0);
    check("midreset_busy", busy, 1'b0);
    alu_op = OP_MFHI;
    #1;
    check("midreset_hi", alu_result, 32'd0);
    alu_op = OP_MFLO;
    #1;
    check("midreset_lo", alu_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("postreset_busy", busy, 1'b0);
    alu_op = OP_MTHI; alu_rs = 32'hA5;
    tick();
    alu_op = OP_MFHI;
    #1;
    check("postreset_mthi", alu_result, 32'hA5);
    $display("reset mid-divide then mthi value=%h", alu_result);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
